// File: rtl/systolic_ctrl_if.sv
// Signal bundle between the systolic sequencer, its command host and the array/buffer side.
// master = sequencer, slave = host/array/buffers.
interface systolic_ctrl_if #(
  parameter int N  = 4,
  parameter int AW = 8
);
  logic          start;
  logic          abort;
  logic [AW-1:0] cfg_rows;
  logic          busy;
  logic          done;
  logic          wfetch;
  logic [AW-1:0] w_rd_addr;
  logic [N-1:0]  if_en;
  logic          in_rd_en;
  logic [AW-1:0] in_rd_addr;
  logic          of_capture;
  logic [AW-1:0] out_wr_addr;

  modport master (
    input  start, abort, cfg_rows,
    output busy, done, wfetch, w_rd_addr, if_en, in_rd_en, in_rd_addr,
           of_capture, out_wr_addr
  );

  modport slave (
    output start, abort, cfg_rows,
    input  busy, done, wfetch, w_rd_addr, if_en, in_rd_en, in_rd_addr,
           of_capture, out_wr_addr
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N systolic array: weight preload, skewed input streaming,
// output capture timing and a one-cycle done pulse. All outputs are registered.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start; all outputs low
// S_LOAD_W | weight rows 0..N-1 fetched, one per cycle
// S_STREAM | stream counter k = 0..M+N-2 drives skewed if_en / reads
// S_DRAIN  | stream finished, remaining output captures only
// S_DONE   | one-cycle done pulse, back to S_IDLE
module systolic_ctrl #(
  parameter int N       = 4,
  parameter int AW      = 8,
  parameter int OUT_LAT = 8
) (
  input  logic           clk,
  input  logic           rst,
  systolic_ctrl_if.master bus
);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] N_C   = CW'(N);
  localparam logic [CW-1:0] LAT_C = CW'(OUT_LAT);
  localparam logic [AW-1:0] LAT_A = AW'(OUT_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] t, t_nx;
  logic [AW-1:0] m, m_nx;
  logic [CW-1:0] m_ext, mn_ext, last_k, last_cap;
  logic          streaming, capturing;

  logic          busy_q, busy_nx;
  logic          done_q, done_nx;
  logic          wfetch_q, wfetch_nx;
  logic [AW-1:0] w_rd_addr_q, w_rd_addr_nx;
  logic [N-1:0]  if_en_q, if_en_nx;
  logic          in_rd_en_q, in_rd_en_nx;
  logic [AW-1:0] in_rd_addr_q, in_rd_addr_nx;
  logic          of_capture_q, of_capture_nx;
  logic [AW-1:0] out_wr_addr_q, out_wr_addr_nx;

  // One counter t serves as weight row index in LOAD_W and as the stream
  // counter k in STREAM/DRAIN; captures are t-OUT_LAT since both start together.
  always_comb begin
    state_nx = state;
    t_nx     = t;
    m_nx     = m;
    m_ext    = {1'b0, m};
    last_k   = m_ext + N_C - CW'(2);
    last_cap = m_ext + LAT_C - CW'(1);

    if (bus.abort) begin
      state_nx = S_IDLE;
      t_nx     = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            m_nx     = bus.cfg_rows;
            t_nx     = '0;
            state_nx = (bus.cfg_rows == '0) ? S_DONE : S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (t == N_C - CW'(1)) begin
            state_nx = S_STREAM;
            t_nx     = '0;
          end else begin
            t_nx = t + CW'(1);
          end
        end
        S_STREAM: begin
          t_nx = t + CW'(1);
          if (t == last_k) begin
            state_nx = (t == last_cap) ? S_DONE : S_DRAIN;
          end
        end
        S_DRAIN: begin
          t_nx = t + CW'(1);
          if (t == last_cap) begin
            state_nx = S_DONE;
          end
        end
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Outputs are derived from the next state/counter so they register in step with it.
  always_comb begin
    mn_ext         = {1'b0, m_nx};
    busy_nx        = (state_nx != S_IDLE);
    done_nx        = (state_nx == S_DONE);
    wfetch_nx      = (state_nx == S_LOAD_W);
    w_rd_addr_nx   = wfetch_nx ? t_nx[AW-1:0] : '0;
    streaming      = (state_nx == S_STREAM);
    capturing      = ((state_nx == S_STREAM) || (state_nx == S_DRAIN)) &&
                     (t_nx >= LAT_C) && (t_nx < LAT_C + mn_ext);
    in_rd_en_nx    = streaming && (t_nx < mn_ext);
    in_rd_addr_nx  = in_rd_en_nx ? t_nx[AW-1:0] : '0;
    of_capture_nx  = capturing;
    out_wr_addr_nx = capturing ? (t_nx[AW-1:0] - LAT_A) : '0;
    if_en_nx       = '0;
    for (int i = 0; i < N; i++) begin
      if_en_nx[i] = streaming && (t_nx >= CW'(i)) && ((t_nx - CW'(i)) < mn_ext);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      t             <= '0;
      m             <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wfetch_q      <= 1'b0;
      w_rd_addr_q   <= '0;
      if_en_q       <= '0;
      in_rd_en_q    <= 1'b0;
      in_rd_addr_q  <= '0;
      of_capture_q  <= 1'b0;
      out_wr_addr_q <= '0;
    end else begin
      state         <= state_nx;
      t             <= t_nx;
      m             <= m_nx;
      busy_q        <= busy_nx;
      done_q        <= done_nx;
      wfetch_q      <= wfetch_nx;
      w_rd_addr_q   <= w_rd_addr_nx;
      if_en_q       <= if_en_nx;
      in_rd_en_q    <= in_rd_en_nx;
      in_rd_addr_q  <= in_rd_addr_nx;
      of_capture_q  <= of_capture_nx;
      out_wr_addr_q <= out_wr_addr_nx;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.wfetch      = wfetch_q;
  assign bus.w_rd_addr   = w_rd_addr_q;
  assign bus.if_en       = if_en_q;
  assign bus.in_rd_en    = in_rd_en_q;
  assign bus.in_rd_addr  = in_rd_addr_q;
  assign bus.of_capture  = of_capture_q;
  assign bus.out_wr_addr = out_wr_addr_q;
endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for the N×N `systolic` array. On one `start` command it:

- preloads N weight rows through the array's `wfetch` path;
- streams M input vectors with per-row skewed `if_en`;
- times the capture of M output vectors into the output buffer;
- reports completion with a one-cycle `done`.

It sits between the host/command interface and the array, and drives the weight/input buffer read ports and the output buffer write port.

## Interface

Parameters:
- `N`, 4, array dimension (rows = columns); `if_en` width.
- `AW`, 8, buffer address width; M ranges 0..2^AW−1.
- `OUT_LAT`, 8, cycles from the first stream cycle to the first valid `of_data` row. Must be ≥ N−1.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  command strobe; sampled only in IDLE.
- `abort`  in  1  synchronous abort; takes priority over all other inputs.
- `cfg_rows`  in  AW  M, the number of input vectors; latched on an accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on completion.
- `wfetch`  out  1  weight-load enable to the array.
- `w_rd_addr`  out  AW  weight buffer row address.
- `if_en`  out  N  per-row input enable to the array.
- `in_rd_en`  out  1  input buffer read strobe.
- `in_rd_addr`  out  AW  input vector index.
- `of_capture`  out  1  output buffer write strobe.
- `out_wr_addr`  out  AW  output buffer row address.

## Operation

- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- All outputs are registered. While `rst`=0, every output is 0 and the FSM is in IDLE.
- **IDLE**
  - On `start`=1: latch `cfg_rows` into M.
  - If M=0, go to DONE; no enable is ever asserted.
  - Otherwise go to LOAD_W.
- **LOAD_W** (N cycles)
  - `wfetch`=1.
  - `w_rd_addr` = 0,1,…,N−1, one row per cycle.
  - Then go to STREAM.
- **STREAM** (M+N−1 cycles)
  - A stream counter k runs 0..M+N−2.
  - `if_en[i]`=1 iff i ≤ k ≤ i+M−1.
  - `in_rd_en`=1 and `in_rd_addr`=k for k < M.
  - Capture logic runs independently (see Timing), so capture may overlap STREAM.
  - Go to DRAIN when k = M+N−2.
  - If the last capture also completes in that cycle, go directly to DONE.
- **DRAIN**: hold all enables low except `of_capture`. Go to DONE after the last capture cycle.
- **DONE**: `done`=1 for exactly one cycle, then IDLE.
- **Abort**: in any non-IDLE state, `abort`=1 forces IDLE on the next edge. All enables drop to 0 and `done` is not pulsed.
- **start while busy**: ignored. No queueing, no error flag.
- **start and abort together in IDLE**: abort wins; the command is not accepted.
- **Counters and wrap**
  - Counters are AW+1 bits wide to hold M+N−1 and OUT_LAT+M without wrap.
  - Address outputs are the low AW bits.
  - M = 2^AW−1 must complete correctly.

## Timing

Cycle 0 is the edge where `start` is sampled.

- `busy`: rises at cycle 1 and stays high through the DONE cycle.
- `wfetch`: high at cycles 1..N.
- STREAM: cycles N+1 .. 2N+M−1.
- `in_rd_en`: high at cycles N+1 .. N+M.
- `of_capture`: high at cycles N+1+OUT_LAT .. N+OUT_LAT+M, with `out_wr_addr` = 0..M−1.
- `done`: at cycle N+OUT_LAT+M+1; IDLE at the next cycle.
  - The final STREAM cycle is 2N+M−1 and N+OUT_LAT+M+1 ≥ 2N+M always holds, so `done` always follows the end of STREAM.
- M=0: `busy` and `done` are both high at cycle 1; IDLE at cycle 2.
- Back-to-back commands: a new `start` may be sampled in the cycle after `done`.
- Reset mid-operation: asynchronous; outputs go to 0 immediately, not at the next edge.

## Test plan

All scenarios use N=4, OUT_LAT=8 unless stated otherwise.

- **Nominal, M=5**
  - `wfetch` high at cycles 1–4 with `w_rd_addr` 0–3.
  - `if_en` = 0001@5, 0011@6, 1111@8–9, 1110@10, 1000@12, 0000@13.
  - `in_rd_en` high at 5–9.
  - `of_capture` high at 13–17 with addresses 0–4.
  - `done` at 18.
- **M=0**: `start` at cycle 0 → `done` and `busy` at cycle 1; `wfetch`, `if_en` and `of_capture` never asserted.
- **Abort mid-STREAM**: M=5, `abort`=1 at cycle 7 → all outputs 0 from cycle 8, no `done`, FSM in IDLE. A fresh `start` then completes normally.
- **Async reset mid-STREAM**: `rst` low at cycle 6.5 → outputs 0 before the next edge. After release, a `start` completes with identical timing.
- **Ignored start**: `start` pulses at cycles 3 and 10 during an M=5 run → timing identical to the nominal case, single `done`. A `start` at cycle 19 is accepted.
- **Max M**: M=255, OUT_LAT=3 (captures overlap STREAM) → 255 captures with `out_wr_addr` 0..254 and no wrap; `done` at N+OUT_LAT+M+1 = 263.
